jericalla_sequencer: RTL
========================

# jericalla_sequencer

Instruction issuer for the JERICALLA datapath. Holds a small program of 17-bit JERICALLA instruction words, `{dirR[3:0], op[3:0], dir2[3:0], dir1[3:0], EN}`, loaded through a write port. On `start` it presents those words on `instr_out`, one per clock, to the datapath's `in` bus. It watches the datapath's combinational `ZF` so a run can optionally halt on a zero result, and reports completion or abort.

## Interface
- `DEPTH`, default 16: number of program slots; must be a power of two, at most 16.
- `AW`, default 4: slot address width, equal to log2(DEPTH).
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `load_en` input, 1 bit: write `load_data` into slot `load_addr`.
- `load_addr` input, AW bits: program slot to write.
- `load_data` input, 17 bits: instruction word to store.
- `len` input, AW+1 bits: number of instructions to run; sampled only at start.
- `halt_on_zf` input, 1 bit: enables halt-on-zero; sampled only at start.
- `start` input, 1 bit: begin a run from slot 0.
- `stop` input, 1 bit: abort the current run.
- `zf_in` input, 1 bit: datapath ZF for the word currently on `instr_out`.
- `instr_out` output, 17 bits: registered instruction word driven to the datapath `in`.
- `pc` output, AW bits: slot index of the word currently on `instr_out`.
- `busy` output, 1 bit: high while an instruction is being presented.
- `done` output, 1 bit: one-cycle pulse when a run completes normally or by ZF halt.
- `zf_halt` output, 1 bit: last run ended by ZF halt; sticky until the next accepted start.
- `aborted` output, 1 bit: last run ended by `stop`; sticky until the next accepted start.

## Operation
- Program store: DEPTH×17 register array. It is not reset, and its contents are undefined until loaded.
- States:
  - IDLE: `instr_out` = 0, so EN = 0 and the datapath RAM does not write. `busy` = 0.
  - RUN: `instr_out` = mem[`pc`]. `busy` = 1.
  - DONE: `instr_out` = 0. `done` = 1 for exactly one cycle, then the block returns to IDLE.
- IDLE behaviour:
  - `load_en` writes the store only in IDLE and only when `start` = 0. It is ignored in RUN and DONE.
  - `start` = 1 with `stop` = 0 and `len` ≠ 0: latch `len` and `halt_on_zf`, clear `zf_halt` and `aborted`, set `pc` = 0, go to RUN.
  - `start` with `len` = 0: go directly to DONE. No word is issued, and the sticky flags are cleared.
  - `start` and `stop` high together: `stop` wins and the block stays in IDLE. The start is not accepted and the flags are unchanged.
- RUN behaviour, evaluated in priority order:
  1. `stop` = 1: go to IDLE and set `aborted`. There is no `done` pulse.
  2. Latched halt_on_zf = 1 and `zf_in` = 1: the current word is the last one. Go to DONE and set `zf_halt`.
  3. `pc` = latched len − 1: go to DONE.
  4. Otherwise: `pc` ← `pc` + 1.
- `start` is ignored in RUN and DONE. `stop` is ignored in DONE and IDLE, apart from the tie rule above.
- Arithmetic: `len` is AW+1 bits, with valid range 0..DEPTH. A value of `len` > DEPTH is clamped to DEPTH at latch time. `pc` never wraps within a run.
- Reset values: state IDLE, `instr_out` = 0, `pc` = 0, `busy` = 0, `done` = 0, `zf_halt` = 0, `aborted` = 0.
- Reset asserted mid-run forces IDLE immediately, with EN low asynchronously. Store contents are preserved.

## Timing
- Start latency: `start` sampled at edge T puts mem[0] on `instr_out` in the cycle after T.
- Issue rate: one word per cycle. Word k is present in cycle T+1+k, for k = 0..len−1. `busy` is high over the same cycles.
- Normal completion: `done` is high in cycle T+1+len, and `instr_out` = 0 in that cycle. IDLE follows, so a new `start` is accepted at the earliest in cycle T+2+len.
- ZF sampling: `zf_in` is sampled at the end of the cycle in which its word is presented. This matches the combinational ROM→ALU path, so ZF belongs to the same cycle's word.
- ZF halt on word k: `done` and `instr_out` = 0 occur in cycle T+2+k.
- Stop: `stop` high during cycle c of RUN gives `instr_out` = 0 and `busy` = 0 in cycle c+1. The word presented in cycle c was still issued.
- `pc`, `busy` and `instr_out` change only on clock edges, except for asynchronous reset.

## Test plan
- Reset with `clk` running, then load slots 0..2 = 17'h0_2003, 17'h1_4105, 17'h1_8207. Start with `len` = 3 and `halt_on_zf` = 0. Required: the three words appear on consecutive cycles with `pc` = 0,1,2 and `busy` = 1, followed by a one-cycle `done` with `instr_out` = 0.
- Start with `len` = 0: `done` pulses one cycle after the start, `busy` never rises, and `instr_out` stays 0.
- Start with `len` = 4 and `halt_on_zf` = 1, with `zf_in` = 1 while `pc` = 1. Required: the next cycle has `instr_out` = 0 and `done` = 1, and `zf_halt` stays 1 until the next start.
- Start with `len` = 16, then pulse `stop` at `pc` = 5. Required: the next cycle has `instr_out` = 0, no `done`, `aborted` = 1. A `load_en` during RUN leaves the store unchanged.
- Start with `len` = 31: exactly 16 words are issued and `pc` ends at 15 without wrapping. Separately, `start` and `stop` in the same IDLE cycle cause no run and leave the flags unchanged.
- Assert `rst_n` low at `pc` = 3 of a run: `instr_out` = 0 immediately and all outputs take their reset values. A subsequent start with `len` = 2 re-issues the preserved slots 0 and 1.

Source files
------------

// File: rtl/jericalla_sequencer_if.sv
// Bus between the JERICALLA program sequencer and its controller: program
// load port, run control, datapath ZF feedback and issue/status outputs.
interface jericalla_sequencer_if #(
  parameter int AW = 4
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [16:0]   load_data;
  logic [AW:0]   len;
  logic          halt_on_zf;
  logic          start;
  logic          stop;
  logic          zf_in;
  logic [16:0]   instr_out;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          zf_halt;
  logic          aborted;

  modport master (
    output load_en, load_addr, load_data, len, halt_on_zf, start, stop, zf_in,
    input  instr_out, pc, busy, done, zf_halt, aborted
  );

  modport slave (
    input  load_en, load_addr, load_data, len, halt_on_zf, start, stop, zf_in,
    output instr_out, pc, busy, done, zf_halt, aborted
  );
endinterface

// File: rtl/jericalla_sequencer.sv
// Issues a loaded program of 17-bit JERICALLA words to the datapath, one per
// clock, with optional halt on the datapath's zero flag and external abort.
module jericalla_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jericalla_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] pc_q;
  logic [AW:0]   len_q;
  logic          hz_q;
  logic          zf_halt_q;
  logic          aborted_q;
  logic          accept;
  logic          last;
  logic          zf_hit;

  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    return (l > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : l;
  endfunction

  assign accept = (state_q == S_IDLE) && bus.start && !bus.stop;
  assign last   = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign zf_hit = hz_q && bus.zf_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (bus.len == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (bus.stop)       state_d = S_IDLE;
        else if (zf_hit)    state_d = S_DONE;
        else if (last)      state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_out = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      S_RUN: begin
        bus.instr_out = mem[pc_q];
        bus.busy      = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Run control: pc, latched run parameters and sticky end-of-run flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      len_q     <= '0;
      hz_q      <= 1'b0;
      zf_halt_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          zf_halt_q <= 1'b0;
          aborted_q <= 1'b0;
          if (bus.len != '0) begin
            pc_q  <= '0;
            len_q <= clamp_len(bus.len);
            hz_q  <= bus.halt_on_zf;
          end
        end
        S_RUN: begin
          if (bus.stop)     aborted_q <= 1'b1;
          else if (zf_hit)  zf_halt_q <= 1'b1;
          else if (!last)   pc_q      <= pc_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Program store keeps its contents across reset
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.load_en && !bus.start)
      mem[bus.load_addr] <= bus.load_data;
  end

  assign bus.pc      = pc_q;
  assign bus.zf_halt = zf_halt_q;
  assign bus.aborted = aborted_q;

endmodule
